// File: rtl/alu_sequencer_if.sv
// Operand/select bus between the BittyPro execute controller (master) and the 16-bit ALU (slave).
interface alu_sequencer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] alu_in_a;
  logic [WIDTH-1:0] alu_in_b;
  logic [3:0]       alu_select;
  logic             alu_mode;
  logic             alu_carry_in;
  logic [WIDTH-1:0] alu_out;
  logic             alu_carry_out;
  logic             alu_compare;

  modport master (
    output alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in,
    input  alu_out, alu_carry_out, alu_compare
  );

  modport slave (
    input  alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in,
    output alu_out, alu_carry_out, alu_compare
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle execute controller: fetch operands, drive the ALU, write back, keep carry/compare flags.
// Optional macro ALU_SEQ_RETIRE_CNT_EN adds a 16-bit retired-instruction counter output.
module alu_sequencer #(
  parameter int WIDTH = 16,
  parameter int RA_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  output logic             instr_ready,
  output logic [RA_W-1:0]  rf_raddr,
  input  logic [WIDTH-1:0] rf_rdata,
  output logic             rf_we,
  output logic [RA_W-1:0]  rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  alu_sequencer_if.master  alu,
  output logic             carry_flag,
  output logic             cmp_flag,
  output logic             done,
  output logic             err
`ifdef ALU_SEQ_RETIRE_CNT_EN
  , output logic [15:0]    retire_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4
  } state_t;

  state_t           state_r;
  logic [15:3]      instr_r;
  logic [WIDTH-1:0] op_a_r;
  logic [RA_W-1:0]  rx_s;
  logic [RA_W-1:0]  ry_s;
  logic             mode_s;
  logic [3:0]       select_s;
  logic             use_carry_s;
  logic             nowb_s;

  // Field decode of the latched instruction word.
  always_comb begin
    rx_s        = instr_r[15:13];
    ry_s        = instr_r[12:10];
    mode_s      = instr_r[9];
    select_s    = instr_r[8:5];
    use_carry_s = instr_r[4];
    nowb_s      = instr_r[3];
  end

  // Sequencer FSM; every output is registered and ALU inputs hold between instructions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= IDLE;
      instr_r          <= '0;
      op_a_r           <= '0;
      instr_ready      <= 1'b1;
      rf_raddr         <= '0;
      rf_we            <= 1'b0;
      rf_waddr         <= '0;
      rf_wdata         <= '0;
      alu.alu_in_a     <= '0;
      alu.alu_in_b     <= '0;
      alu.alu_select   <= 4'h0;
      alu.alu_mode     <= 1'b0;
      alu.alu_carry_in <= 1'b0;
      carry_flag       <= 1'b0;
      cmp_flag         <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
`ifdef ALU_SEQ_RETIRE_CNT_EN
      retire_cnt       <= 16'h0000;
`endif
    end else begin
      done  <= 1'b0;
      err   <= 1'b0;
      rf_we <= 1'b0;
      case (state_r)
        IDLE: begin
          if (instr_valid && instr_ready) begin
            instr_r <= instr[15:3];
            if (instr[2:0] != 3'b000) begin
              err <= 1'b1;
            end else begin
              rf_raddr    <= instr[15:13];
              instr_ready <= 1'b0;
              state_r     <= RD_A;
            end
          end
        end
        RD_A: begin
          op_a_r   <= rf_rdata;
          rf_raddr <= ry_s;
          state_r  <= RD_B;
        end
        // Operand B goes straight into the ALU input register, which doubles as its latch.
        RD_B: begin
          alu.alu_in_a     <= op_a_r;
          alu.alu_in_b     <= rf_rdata;
          alu.alu_select   <= select_s;
          alu.alu_mode     <= mode_s;
          alu.alu_carry_in <= use_carry_s & carry_flag;
          state_r          <= EXEC;
        end
        EXEC: begin
          cmp_flag <= alu.alu_compare;
          // Carry output is meaningless in logic mode, so the flag is held there.
          if (!mode_s) begin
            carry_flag <= alu.alu_carry_out;
          end else begin
            carry_flag <= carry_flag;
          end
          rf_wdata <= alu.alu_out;
          rf_waddr <= rx_s;
          rf_we    <= ~nowb_s;
          done     <= 1'b1;
`ifdef ALU_SEQ_RETIRE_CNT_EN
          retire_cnt <= retire_cnt + 16'h0001;
`endif
          state_r  <= WB;
        end
        WB: begin
          instr_ready <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural register file and ALU around it.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        instr_ready;
  logic [2:0]  rf_raddr;
  logic [15:0] rf_rdata;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        carry_flag;
  logic        cmp_flag;
  logic        done;
  logic        err;
`ifdef ALU_SEQ_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  int checks = 0;
  int errors = 0;

  alu_sequencer_if #(.WIDTH(16)) alu ();

  alu_sequencer #(.WIDTH(16), .RA_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu(alu.master),
    .carry_flag(carry_flag), .cmp_flag(cmp_flag), .done(done), .err(err)
`ifdef ALU_SEQ_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Register file model: combinational read, write on rising edge; bench preload port when DUT idle.
  logic [15:0] rf [8];
  logic        pre_we = 1'b0;
  logic [2:0]  pre_wa = 3'd0;
  logic [15:0] pre_wd = 16'h0000;
  assign rf_rdata = rf[rf_raddr];
  always @(posedge clk) begin
    if (rf_we) rf[rf_waddr] <= rf_wdata;
    else if (pre_we) rf[pre_wa] <= pre_wd;
  end

  // ALU model: 74181-style select codes used by the vectors; logic-mode carry driven 0 on purpose.
  logic [16:0] sum17;
  always_comb begin
    sum17 = {1'b0, alu.alu_in_a} + {1'b0, alu.alu_in_b} + {16'h0000, alu.alu_carry_in};
    alu.alu_compare   = (alu.alu_in_a == alu.alu_in_b);
    alu.alu_carry_out = 1'b0;
    alu.alu_out       = 16'h0000;
    if (!alu.alu_mode) begin
      if (alu.alu_select == 4'h9) {alu.alu_carry_out, alu.alu_out} = sum17;
      else {alu.alu_carry_out, alu.alu_out} = {1'b0, alu.alu_in_a} - {1'b0, alu.alu_in_b};
    end else begin
      case (alu.alu_select)
        4'h6:    alu.alu_out = alu.alu_in_a ^ alu.alu_in_b;
        4'hF:    alu.alu_out = alu.alu_in_a;
        default: alu.alu_out = alu.alu_in_a & alu.alu_in_b;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_wa = a; pre_wd = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issues one instruction; reports done latency (cycles after handshake), write strobe and EXEC carry_in.
  task automatic run_instr(input logic [15:0] w, output int lat, output bit we_seen,
                           output bit cin_exec, output bit busy_ready);
    @(negedge clk);
    instr = w; instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    lat = 0; we_seen = 1'b0; cin_exec = 1'b0; busy_ready = 1'b0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      @(negedge clk);
      if (rf_we) we_seen = 1'b1;
      if (i == 2) busy_ready = instr_ready;
      if (i == 3) cin_exec = alu.alu_carry_in;
      if (done) lat = i;
    end
    @(posedge clk);
    #1;
  endtask

  int lat;
  bit we_seen, cin_exec, busy_ready, seen;
  int d1, d2;

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_ready", instr_ready, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_we", rf_we, 0);
    check("rst_flags", {carry_flag, cmp_flag}, 0);
    check("rst_alu_a", alu.alu_in_a, 0);
    rst_n = 1'b1;

    preload(3'd1, 16'hFFFF); preload(3'd2, 16'h0001);
    preload(3'd3, 16'h00FF); preload(3'd4, 16'h0F0F);
    preload(3'd5, 16'h1234); preload(3'd6, 16'h1234);

    // ADD without carry: wraps to zero, carry set
    run_instr(16'h2920, lat, we_seen, cin_exec, busy_ready);
    check("add_lat", lat, 4);
    check("add_busy_ready", busy_ready, 0);
    check("add_cin", cin_exec, 0);
    check("add_we", we_seen, 1);
    check("add_r1", rf[1], 16'h0000);
    check("add_carry", carry_flag, 1);
    check("add_cmp", cmp_flag, 0);
    check("add_ready_after", instr_ready, 1);

    // ADD with carry: 0 + 1 + 1
    run_instr(16'h2930, lat, we_seen, cin_exec, busy_ready);
    check("adc_lat", lat, 4);
    check("adc_cin", cin_exec, 1);
    check("adc_r1", rf[1], 16'h0002);
    check("adc_carry", carry_flag, 0);

    // Re-arm carry, then XOR in logic mode must hold it
    preload(3'd1, 16'hFFFF);
    run_instr(16'h2920, lat, we_seen, cin_exec, busy_ready);
    check("rearm_carry", carry_flag, 1);
    run_instr(16'h72C0, lat, we_seen, cin_exec, busy_ready);
    check("xor_lat", lat, 4);
    check("xor_r3", rf[3], 16'h0FF0);
    check("xor_carry_held", carry_flag, 1);
    check("xor_cmp", cmp_flag, 0);

    // nowb with equal operands
    run_instr(16'hBBE8, lat, we_seen, cin_exec, busy_ready);
    check("nowb_lat", lat, 4);
    check("nowb_we", we_seen, 0);
    check("nowb_cmp", cmp_flag, 1);
    check("nowb_r5", rf[5], 16'h1234);
    check("nowb_carry", carry_flag, 1);

    // Reserved bits set: err pulse only
    @(negedge clk);
    instr = 16'h2921; instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    check("err_pulse", err, 1);
    check("err_ready", instr_ready, 1);
    check("err_done", done, 0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || err || rf_we) seen = 1'b1;
    end
    check("err_quiet", seen, 0);
    check("err_flags", {carry_flag, cmp_flag}, 2'b11);

`ifdef ALU_SEQ_RETIRE_CNT_EN
    check("retire_cnt", retire_cnt, 5);
`endif

    // Reset asserted during EXEC aborts the instruction
    preload(3'd1, 16'hFFFF);
    @(negedge clk);
    instr = 16'h2920; instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ready", instr_ready, 1);
    check("abort_flags", {carry_flag, cmp_flag}, 0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rf_we || done) seen = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rf_we || done) seen = 1'b1;
    end
    check("abort_no_wb", seen, 0);
    check("abort_r1", rf[1], 16'hFFFF);
    check("abort_idle", instr_ready, 1);

    // instr_valid held high: one instruction per 5 cycles
    @(negedge clk);
    instr = 16'h2920; instr_valid = 1'b1;
    @(posedge clk);
    d1 = 0; d2 = 0;
    for (int i = 1; i <= 14 && d2 == 0; i++) begin
      @(negedge clk);
      if (done && d1 == 0) d1 = i;
      else if (done) begin d2 = i; instr_valid = 1'b0; end
    end
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_first", d1, 4);
    check("b2b_second", d2, 9);
    check("b2b_r1", rf[1], 16'h0001);
    check("b2b_carry", carry_flag, 0);
`ifdef ALU_SEQ_RETIRE_CNT_EN
    check("retire_cnt_b2b", retire_cnt, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle execute controller for the BittyPro datapath; it is the driving end of the 16-bit ALU operand/select interface.
- Accepts one instruction word through a valid/ready handshake and reads two operands from the register file.
- Drives the ALU's carry_in, in_a, in_b, select and mode, then captures alu_out, carry_out and compare.
- Writes the result back to the register file and keeps the carry and compare status flags.

Parameters:
- WIDTH, 16, datapath / operand width.
- RA_W, 3, register-file address width (8 registers).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction word available.
- instr  in  16  instruction word.
- instr_ready  out  1  high only in IDLE.
- rf_raddr  out  RA_W  register-file read address; read data is combinational.
- rf_rdata  in  WIDTH  register-file read data.
- rf_we  out  1  write-back strobe, one cycle.
- rf_waddr  out  RA_W  write-back address.
- rf_wdata  out  WIDTH  write-back data.
- alu_in_a  out  WIDTH  ALU operand A.
- alu_in_b  out  WIDTH  ALU operand B.
- alu_select  out  4  ALU function select.
- alu_mode  out  1  1 = logic, 0 = arithmetic.
- alu_carry_in  out  1  ALU carry input.
- alu_out  in  WIDTH  ALU result.
- alu_carry_out  in  1  ALU carry output.
- alu_compare  in  1  ALU A==B indication.
- carry_flag  out  1  stored carry.
- cmp_flag  out  1  stored compare.
- done  out  1  one-cycle retire pulse.
- err  out  1  one-cycle illegal-instruction pulse.

Behaviour:
- Instruction fields:
  - [15:13] rx: source A and destination.
  - [12:10] ry: source B.
  - [9:5] {mode, select}.
  - [4] use_carry: alu_carry_in = carry_flag when set, else 0.
  - [3] nowb: suppress write-back.
  - [2:0] reserved; must be 000.
- Reset (asynchronous, rst_n low): state = IDLE; all registered outputs 0; carry_flag = 0, cmp_flag = 0, latched operands 0, instr_ready = 1.
- Reset asserted mid-instruction aborts it: no write-back, no done.
- States: IDLE -> RD_A -> RD_B -> EXEC -> WB -> IDLE.
  - IDLE: instr_ready = 1. When instr_valid & instr_ready, latch instr.
    - If [2:0] != 0: pulse err next cycle, stay in IDLE, flags unchanged.
    - Otherwise go to RD_A.
  - RD_A: rf_raddr = rx; latch rf_rdata into op_a at end of cycle.
  - RD_B: rf_raddr = ry; latch op_b.
  - EXEC: alu_in_a = op_a, alu_in_b = op_b, mode/select/carry_in driven from the latched instruction; capture alu_out into result.
    - cmp_flag <= alu_compare always.
    - carry_flag <= alu_carry_out only when mode = 0; held when mode = 1, because the ALU's carry output is undefined in logic mode.
  - WB: rf_we = !nowb, rf_waddr = rx, rf_wdata = result; done = 1 this cycle; return to IDLE.
- Latency: handshake edge to done = 4 cycles. Throughput: one instruction per 5 cycles; no overlap.
- Outside EXEC, ALU input ports hold their last driven values (stable, no X). rf_raddr holds its last value.
- rx == ry is legal: both operands come from the same register.
- The use_carry value is sampled from carry_flag during EXEC, so the previous instruction's carry is always visible.
- instr is ignored when instr_ready = 0; instr_valid may stay high across instructions.
- Arithmetic results wrap modulo 2^WIDTH; the 17th bit appears only via alu_carry_out.

Optional Feature:
- Macro ALU_SEQ_RETIRE_CNT_EN.
- Defined: adds output retire_cnt [15:0]. Reset 0; +1 on each done pulse; wraps 0xFFFF -> 0x0000; err does not count.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- R1 = 0xFFFF, R2 = 0x0001, instr 0x2920 (ADD, no carry) -> done 4 cycles after handshake; R1 = 0x0000, carry_flag = 1, cmp_flag = 0.
- Follow-on 0x2930 (ADD with carry) with R1 = 0x0000, R2 = 0x0001, carry_flag = 1 -> alu_carry_in = 1, R1 = 0x0002, carry_flag = 0.
- R3 = 0x00FF, R4 = 0x0F0F, instr 0x72C0 (XOR, logic mode) with carry_flag = 1 beforehand -> R3 = 0x0FF0, carry_flag stays 1.
- R5 = R6 = 0x1234, instr 0xBBE8 (nowb) -> rf_we never high, cmp_flag = 1, done pulses, R5 unchanged.
- instr 0x2921 (reserved bits nonzero) -> err pulses 1 cycle, no done, instr_ready stays 1, flags unchanged.
- Deassert rst_n during EXEC of 0x2920 -> rf_we stays 0, flags = 0, state IDLE, instr_ready = 1 immediately.
